// File: rtl/obuf_drain_pkg.sv
// Shared types and width helpers for the systolic-array output buffer.
package obuf_pkg;

  typedef enum logic {OBUF_IDLE, OBUF_SEND} obuf_state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obuf_drain_if.sv
// Array-side row write and memory-side word drain signals of the output buffer.
interface obuf_drain_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32
);
  import obuf_pkg::*;

  localparam int COL_W = clog2_min1(ARRAY_SIZE);

  logic                         OBUF_wr_en;
  logic [ARRAY_SIZE*DATA_W-1:0] OBUF_data_in;
  logic                         OBUF_full;
  logic                         OBUF_empty;
  logic                         OBUF_overflow;
  logic                         OBUF_rd_valid;
  logic                         OBUF_rd_ready;
  logic [DATA_W-1:0]            OBUF_data_out;
  logic [COL_W-1:0]             OBUF_col_idx;
  logic                         OBUF_last;
  logic                         OBUF_zero;

  modport master (
    output OBUF_wr_en, OBUF_data_in, OBUF_rd_ready,
    input  OBUF_full, OBUF_empty, OBUF_overflow, OBUF_rd_valid,
    input  OBUF_data_out, OBUF_col_idx, OBUF_last, OBUF_zero
  );

  modport slave (
    input  OBUF_wr_en, OBUF_data_in, OBUF_rd_ready,
    output OBUF_full, OBUF_empty, OBUF_overflow, OBUF_rd_valid,
    output OBUF_data_out, OBUF_col_idx, OBUF_last, OBUF_zero
  );

endinterface

// File: rtl/obuf_row_fifo.sv
// Row-wide FIFO with registered count; head row is visible combinationally.
module obuf_row_fifo
  import obuf_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           nRST,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [clog2_min1(DEPTH):0]     count
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/obuf_drain.sv
// Output buffer: queues full array rows, then serializes them one column word per handshake.
module obuf_drain
  import obuf_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4
) (
  input logic         clk,
  input logic         nRST,
  obuf_drain_if.slave bus
);

  localparam int COL_W = clog2_min1(ARRAY_SIZE);
  localparam int CNT_W = clog2_min1(DEPTH) + 1;
  localparam int ROW_W = ARRAY_SIZE * DATA_W;

  obuf_state_t       state_reg;
  obuf_state_t       state_next;
  logic [ROW_W-1:0]  row_reg;
  logic [ROW_W-1:0]  row_next;
  logic [COL_W-1:0]  col_reg;
  logic [COL_W-1:0]  col_next;
  logic              overflow_reg;

  logic [ROW_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;

  logic [DATA_W-1:0] col_words [ARRAY_SIZE];
  logic [DATA_W-1:0] word;
  logic              sending;
  logic              last_col;
  logic              handshake;

  obuf_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nRST  (nRST),
    .push  (bus.OBUF_wr_en),
    .pop   (fifo_pop),
    .din   (bus.OBUF_data_in),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
    assign col_words[gi] = row_reg[gi*DATA_W +: DATA_W];
  end

  assign word      = col_words[col_reg];
  assign sending   = (state_reg == OBUF_SEND);
  assign last_col  = (col_reg == COL_W'(ARRAY_SIZE - 1));
  assign handshake = sending && bus.OBUF_rd_ready;
  // Reload from the FIFO when idle, or right on the last-column handshake so rows abut.
  assign fifo_pop  = !fifo_empty && (!sending || (handshake && last_col));

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    if (fifo_pop) begin
      state_next = OBUF_SEND;
      row_next   = fifo_head;
      col_next   = '0;
    end else if (handshake) begin
      if (last_col) state_next = OBUF_IDLE;
      else          col_next   = col_reg + COL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_reg    <= OBUF_IDLE;
      row_reg      <= '0;
      col_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      if (bus.OBUF_wr_en && fifo_full) overflow_reg <= 1'b1;
    end
  end

  assign bus.OBUF_rd_valid = sending;
  assign bus.OBUF_data_out = sending ? word : '0;
  assign bus.OBUF_zero     = (bus.OBUF_data_out == '0);
  assign bus.OBUF_col_idx  = col_reg;
  assign bus.OBUF_last     = sending && last_col;
  assign bus.OBUF_full     = fifo_full;
  assign bus.OBUF_empty    = (fifo_count == '0) && !sending;
  assign bus.OBUF_overflow = overflow_reg;

endmodule

// File: tb/tb_obuf_drain.sv
// Randomized and directed bench for obuf_drain against a queue-based reference model.
module tb_obuf_drain;
  import obuf_pkg::*;

  localparam int A = 4;
  localparam int W = 32;
  localparam int D = 4;

  typedef logic [A*W-1:0] row_t;
  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   col;
    logic         zero;
    logic         last;
  } cap_t;

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  obuf_drain_if #(.ARRAY_SIZE(A), .DATA_W(W)) bus ();

  obuf_drain #(.ARRAY_SIZE(A), .DATA_W(W), .DEPTH(D)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;
  cap_t cap[$];

  // Reference: stored rows as a bounded queue plus the row currently being sent.
  row_t m_q[$];
  bit   m_valid = 0;
  row_t m_row   = '0;
  int   m_col   = 0;
  bit   m_ovf   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   hs;
    bit   take;
    bit   was_full;
    row_t hd;
    if (!nRST) begin
      m_q.delete();
      m_valid = 0;
      m_row   = '0;
      m_col   = 0;
      m_ovf   = 0;
      return;
    end
    was_full = (m_q.size() == D);
    hs   = m_valid && bus.OBUF_rd_ready;
    take = (m_q.size() > 0) && (!m_valid || (hs && m_col == A - 1));
    if (take) begin
      hd      = m_q.pop_front();
      m_row   = hd;
      m_col   = 0;
      m_valid = 1;
    end else if (hs) begin
      if (m_col == A - 1) m_valid = 0;
      else                m_col   = m_col + 1;
    end
    if (bus.OBUF_wr_en) begin
      if (was_full) m_ovf = 1;
      else          m_q.push_back(bus.OBUF_data_in);
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    logic [W-1:0] exp_word;
    cap_t c;
    if (chk_en) begin
      chk("valid", bus.OBUF_rd_valid, m_valid);
      chk("full", bus.OBUF_full, m_q.size() == D);
      chk("empty", bus.OBUF_empty, (m_q.size() == 0) && !m_valid);
      chk("overflow", bus.OBUF_overflow, m_ovf);
      chk("last", bus.OBUF_last, m_valid && (m_col == A - 1));
      if (m_valid) begin
        exp_word = m_row[m_col*W +: W];
        chk("data", bus.OBUF_data_out, exp_word);
        chk("col_idx", bus.OBUF_col_idx, m_col);
        chk("zero", bus.OBUF_zero, exp_word == 0);
      end
      if (bus.OBUF_rd_valid && bus.OBUF_rd_ready) begin
        c.data = bus.OBUF_data_out;
        c.col  = bus.OBUF_col_idx;
        c.zero = bus.OBUF_zero;
        c.last = bus.OBUF_last;
        cap.push_back(c);
        $display("[TB] word data=%08h col=%0d last=%0b zero=%0b", c.data, c.col, c.last, c.zero);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk_row(input int base);
    row_t r;
    for (int c = 0; c < A; c++) r[c*W +: W] = W'(base + c);
    return r;
  endfunction

  initial begin
    row_t r;
    nRST = 1'b0;
    bus.OBUF_wr_en    = 1'b1;
    bus.OBUF_data_in  = mk_row(32'h77);
    bus.OBUF_rd_ready = 1'b0;

    // Reset held two cycles with a write strobe active
    tick();
    chk_en = 1;
    tick();
    nRST = 1'b1;
    bus.OBUF_wr_en = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.OBUF_rd_valid, 0);
    chk("rst_empty", bus.OBUF_empty, 1);
    chk("rst_full", bus.OBUF_full, 0);
    chk("rst_ovf", bus.OBUF_overflow, 0);
    chk("rst_data", bus.OBUF_data_out, 0);
    chk("rst_zero", bus.OBUF_zero, 1);
    tick();

    // Single row with ready high: 2-cycle latency, words 1..4
    cap.delete();
    bus.OBUF_rd_ready = 1'b1;
    bus.OBUF_data_in  = {32'h4, 32'h3, 32'h2, 32'h1};
    bus.OBUF_wr_en    = 1'b1;
    tick();
    bus.OBUF_wr_en = 1'b0;
    @(negedge clk);
    chk("lat_valid_t", bus.OBUF_rd_valid, 0);
    chk("lat_empty_t", bus.OBUF_empty, 0);
    tick();
    @(negedge clk);
    chk("lat_valid_t1", bus.OBUF_rd_valid, 1);
    chk("lat_col_t1", bus.OBUF_col_idx, 0);
    chk("lat_data_t1", bus.OBUF_data_out, 32'h1);
    repeat (6) tick();
    chk("single_cnt", cap.size(), 4);
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      chk("single_data", cap[i].data, i + 1);
      chk("single_col", cap[i].col, i);
      chk("single_last", cap[i].last, i == 3);
    end

    // Backpressure: ready pattern 1,0,0 repeating over two rows
    cap.delete();
    for (int k = 0; k < 40; k++) begin
      bus.OBUF_wr_en    = (k < 2);
      bus.OBUF_data_in  = mk_row((k + 1) * 32'h100);
      bus.OBUF_rd_ready = (k % 3 == 0);
      tick();
    end
    bus.OBUF_wr_en = 1'b0;
    chk("bp_cnt", cap.size(), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      chk("bp_data", cap[i].data, (i / 4 + 1) * 32'h100 + i % 4);

    // Fill: six writes with no ready; the sixth is dropped
    bus.OBUF_rd_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.OBUF_wr_en   = 1'b1;
      bus.OBUF_data_in = mk_row(k * 16);
      tick();
    end
    bus.OBUF_wr_en = 1'b0;
    @(negedge clk);
    chk("fill_full", bus.OBUF_full, 1);
    chk("fill_ovf", bus.OBUF_overflow, 1);
    chk("fill_valid", bus.OBUF_rd_valid, 1);
    tick();
    cap.delete();
    bus.OBUF_rd_ready = 1'b1;
    repeat (30) tick();
    chk("fill_cnt", cap.size(), 20);
    for (int i = 0; i < 20 && i < cap.size(); i++)
      chk("fill_data", cap[i].data, (i / 4 + 1) * 16 + i % 4);
    chk("fill_ovf_hold", bus.OBUF_overflow, 1);

    // Zero flag per column
    cap.delete();
    bus.OBUF_data_in = {32'h0, 32'h7, 32'h0, 32'hFFFFFFFF};
    bus.OBUF_wr_en   = 1'b1;
    tick();
    bus.OBUF_wr_en = 1'b0;
    repeat (7) tick();
    chk("zero_cnt", cap.size(), 4);
    for (int i = 0; i < 4 && i < cap.size(); i++)
      chk("zero_flag", cap[i].zero, i % 2);

    // Reset in the middle of a row with two more rows queued
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    bus.OBUF_rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.OBUF_wr_en   = 1'b1;
      bus.OBUF_data_in = mk_row(32'h300 + k * 16);
      tick();
    end
    bus.OBUF_wr_en    = 1'b0;
    bus.OBUF_rd_ready = 1'b1;
    tick();
    tick();
    bus.OBUF_rd_ready = 1'b0;
    @(negedge clk);
    chk("mid_col", bus.OBUF_col_idx, 2);
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    @(negedge clk);
    chk("mid_valid", bus.OBUF_rd_valid, 0);
    chk("mid_empty", bus.OBUF_empty, 1);
    tick();
    cap.delete();
    bus.OBUF_rd_ready = 1'b1;
    bus.OBUF_wr_en    = 1'b1;
    bus.OBUF_data_in  = mk_row(32'h500);
    tick();
    bus.OBUF_wr_en = 1'b0;
    repeat (7) tick();
    chk("mid_cnt", cap.size(), 4);
    if (cap.size() > 0) begin
      chk("mid_col0", cap[0].col, 0);
      chk("mid_data0", cap[0].data, 32'h500);
    end

    // Random traffic with phases of varying write and ready pressure
    for (int ph = 0; ph < 6; ph++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = $urandom_range(10, 90);
      rd_pct = $urandom_range(10, 100);
      for (int k = 0; k < 400; k++) begin
        for (int c = 0; c < A; c++)
          r[c*W +: W] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom());
        bus.OBUF_data_in  = r;
        bus.OBUF_wr_en    = ($urandom_range(0, 99) < wr_pct);
        bus.OBUF_rd_ready = ($urandom_range(0, 99) < rd_pct);
        nRST              = ($urandom_range(0, 199) != 0);
        tick();
      end
    end
    nRST = 1'b1;
    bus.OBUF_wr_en    = 1'b0;
    bus.OBUF_rd_ready = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("final_empty", bus.OBUF_empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/obuf_drain.md
# obuf_drain

Output buffer for the BitFusion systolic array: captures one full row of ARRAY_SIZE column results per write strobe into a small row FIFO, then serializes each row to the memory side one DATA_W word at a time over a valid/ready handshake. It sits between the array's column outputs and the result-writeback path. It is the drain-side counterpart of the input buffer that feeds the array. Each outgoing word carries a zero flag so writeback can skip all-zero results.

## Interface
- ARRAY_SIZE, 4, number of array columns, i.e. words per row (power of 2, ≥2)
- DATA_W, 32, width of one column result word
- DEPTH, 4, row FIFO depth in rows (power of 2, ≥2)

- clk  in  1  clock; all logic on rising edge
- nRST  in  1  reset, synchronous, active-low
- OBUF_wr_en  in  1  row write strobe from array
- OBUF_data_in  in  ARRAY_SIZE*DATA_W  row; column c at bits [c*DATA_W +: DATA_W]
- OBUF_full  out  1  FIFO holds DEPTH rows
- OBUF_empty  out  1  FIFO empty and drain register idle
- OBUF_overflow  out  1  sticky: a write was dropped while full
- OBUF_rd_valid  out  1  OBUF_data_out valid
- OBUF_rd_ready  in  1  consumer accepts word
- OBUF_data_out  out  DATA_W  current word
- OBUF_col_idx  out  $clog2(ARRAY_SIZE)  column of current word
- OBUF_last  out  1  current word is column ARRAY_SIZE-1
- OBUF_zero  out  1  OBUF_data_out == 0; meaningful only with rd_valid

## Operation
- Row FIFO: write when OBUF_wr_en && !OBUF_full. Writing while full drops the row and sets OBUF_overflow, which holds until reset. The full check uses the registered count, so a pop in the same cycle does not admit a write.
- Drain FSM states:
  - IDLE: rd_valid=0. If FIFO is non-empty, pop the head into the row register, set col_idx=0, and go to SEND.
  - SEND: rd_valid=1, data_out=row[col_idx].
- SEND handshake:
  - On rd_valid && rd_ready with col_idx < ARRAY_SIZE-1: col_idx+1.
  - On the handshake at the last column: if FIFO is non-empty, pop the next row, set col_idx=0, and stay in SEND (no bubble). Otherwise go to IDLE.
- Without ready, data_out, col_idx, last and zero are held stable. Valid is never withdrawn before the handshake.
- OBUF_last = (state==SEND) && col_idx==ARRAY_SIZE-1.
- OBUF_empty = (count==0) && state==IDLE.
- FIFO count excludes the row in the drain register. Total buffering is DEPTH+1 rows.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Simultaneous write and pop (not full): count unchanged, both pointers advance.

## Timing
- Reset (nRST=0 at a clk edge): state=IDLE, pointers/count=0, row register=0, col_idx=0. Outputs: rd_valid=0, data_out=0, last=0, zero=1, full=0, empty=1, overflow=0.
- Reset mid-drain discards the row register and all FIFO contents.
- Write at edge t into an empty buffer: empty=0 after t. The FSM pops at t+1; rd_valid=1 with column 0 after t+1. Latency is 2 cycles from strobe to first word.
- With ready held high: one word per cycle, back-to-back rows with no gap. A row drains in ARRAY_SIZE cycles.
- full rises the cycle after the DEPTH-th stored write and falls the cycle after a pop.

## Structure
- Package obuf_pkg:
  - typedef enum logic {OBUF_IDLE, OBUF_SEND} obuf_state_t
  - localparam helpers for col-index and pointer widths
- Sub-module obuf_row_fifo: ARRAY_SIZE*DATA_W wide, DEPTH deep, synchronous active-low reset, with push/pop/full/empty/count.
- Top level holds the drain FSM, row register, col counter, overflow flag and zero compare.

## Test plan
- Reset: hold nRST=0 for 2 cycles with wr_en=1 -> rd_valid=0, empty=1, full=0, overflow=0, data_out=0.
- Single row {0x4,0x3,0x2,0x1} (col0=0x1), ready=1 -> words 0x1,0x2,0x3,0x4 on consecutive cycles starting 2 cycles after strobe; col_idx 0..3; last only on 0x4; then IDLE.
- Backpressure: ready toggles 1,0,0,1,... -> each word held stable while ready=0; no word lost or duplicated.
- Fill: 6 consecutive writes with ready=0 -> 1 row in drain register, 4 in FIFO, full=1, 6th write dropped, overflow=1. Draining yields exactly rows 1–5 in order; overflow stays 1.
- Zero flag: row {0x0,0x7,0x0,0xFFFFFFFF} -> zero=0,1,0,1 for columns 0..3.
- Reset mid-drain: assert nRST=0 during column 2 of a row with 2 rows queued -> next cycle rd_valid=0, empty=1. A new write drains normally from column 0.
